// File: rtl/mmio_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the MMIO controller, with a
// per-strobe watchdog that completes any unacknowledged access with canned read data.
module mmio_arbiter #(
   parameter int unsigned            ADDR_WIDTH     = 11,
   parameter int unsigned            DATA_WIDTH     = 32,
   parameter int unsigned            TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0]  TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic                  M0_CYC_I,
   input  logic                  M0_STB_I,
   input  logic                  M0_WE_I,
   input  logic [ADDR_WIDTH-1:0] M0_ADDR_I,
   input  logic [DATA_WIDTH-1:0] M0_DAT_I,
   output logic [DATA_WIDTH-1:0] M0_DAT_O,
   output logic                  M0_ACK_O,
   input  logic                  M1_CYC_I,
   input  logic                  M1_STB_I,
   input  logic                  M1_WE_I,
   input  logic [ADDR_WIDTH-1:0] M1_ADDR_I,
   input  logic [DATA_WIDTH-1:0] M1_DAT_I,
   output logic [DATA_WIDTH-1:0] M1_DAT_O,
   output logic                  M1_ACK_O,
   output logic                  S_CYC_O,
   output logic                  S_STB_O,
   output logic                  S_WE_O,
   output logic [ADDR_WIDTH-1:0] S_ADDR_O,
   output logic [DATA_WIDTH-1:0] S_DAT_O,
   input  logic [DATA_WIDTH-1:0] S_DAT_I,
   input  logic                  S_ACK_I,
   output logic [1:0]            GNT_O,
   output logic                  TIMEOUT_O
);

   localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

   state_e                 state_q, state_d;
   logic                   gnt_idx_q, gnt_idx_d;
   logic                   last_q, last_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic                   owner_cyc, owner_stb, owner_we;
   logic [ADDR_WIDTH-1:0]  owner_addr;
   logic [DATA_WIDTH-1:0]  owner_dat;
   logic                   granted, aborting;

   assign owner_cyc  = gnt_idx_q ? M1_CYC_I  : M0_CYC_I;
   assign owner_stb  = gnt_idx_q ? M1_STB_I  : M0_STB_I;
   assign owner_we   = gnt_idx_q ? M1_WE_I   : M0_WE_I;
   assign owner_addr = gnt_idx_q ? M1_ADDR_I : M0_ADDR_I;
   assign owner_dat  = gnt_idx_q ? M1_DAT_I  : M0_DAT_I;
   assign granted    = (state_q == StGrant);
   assign aborting   = (state_q == StAbort);

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q   <= StIdle;
         gnt_idx_q <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      last_d    = last_q;
      cnt_d     = '0;
      case (state_q)
         StIdle: begin
            if (M0_CYC_I || M1_CYC_I) begin
               state_d = StGrant;
               // A tie goes to whoever did not win last time.
               if (M0_CYC_I && M1_CYC_I) gnt_idx_d = ~last_q;
               else                      gnt_idx_d = M1_CYC_I;
               last_d = gnt_idx_d;
            end
         end
         StGrant: begin
            if (!owner_cyc) begin
               state_d = StIdle;
            end else if (owner_stb && !S_ACK_I) begin
               if (cnt_q == CNT_LIMIT) state_d = StAbort;
               else                    cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
         end
         StAbort: state_d = StGrant;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      S_CYC_O   = granted & owner_cyc;
      S_STB_O   = granted & owner_stb;
      S_WE_O    = granted & owner_we;
      S_ADDR_O  = granted ? owner_addr : '0;
      S_DAT_O   = granted ? owner_dat  : '0;
      M0_ACK_O  = ~gnt_idx_q & ((granted & S_ACK_I) | aborting);
      M1_ACK_O  =  gnt_idx_q & ((granted & S_ACK_I) | aborting);
      M0_DAT_O  = (aborting && !gnt_idx_q) ? TIMEOUT_DATA : S_DAT_I;
      M1_DAT_O  = (aborting &&  gnt_idx_q) ? TIMEOUT_DATA : S_DAT_I;
      GNT_O     = (state_q == StIdle) ? 2'b00 : (gnt_idx_q ? 2'b10 : 2'b01);
      TIMEOUT_O = aborting;
   end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed and randomized bench for mmio_arbiter, checked against a cycle model
// built from the arbitration and watchdog rules.
module tb_mmio_arbiter;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int T  = 8;
   localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat;
   logic          m0_ack, m1_ack;
   logic          s_cyc, s_stb, s_we, s_ack;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdat, s_rdat;
   logic [1:0]    gnt;
   logic          tmo;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 = idle, 1 = owned, 2 = abort response
   int m_st = 0, m_owner = 0, m_last = 1, m_wait = 0;

   always #5 clk = ~clk;

   mmio_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TDATA)
   ) dut (
      .CLK_I(clk), .RST_I(rst),
      .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADDR_I(m0_addr),
      .M0_DAT_I(m0_wdat), .M0_DAT_O(m0_rdat), .M0_ACK_O(m0_ack),
      .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADDR_I(m1_addr),
      .M1_DAT_I(m1_wdat), .M1_DAT_O(m1_rdat), .M1_ACK_O(m1_ack),
      .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADDR_O(s_addr),
      .S_DAT_O(s_wdat), .S_DAT_I(s_rdat), .S_ACK_I(s_ack),
      .GNT_O(gnt), .TIMEOUT_O(tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic req_cyc(input int m);
      return (m == 1) ? m1_cyc : m0_cyc;
   endfunction

   function automatic logic req_stb(input int m);
      return (m == 1) ? m1_stb : m0_stb;
   endfunction

   task automatic model_check();
      logic own, ab;
      logic [31:0] e_addr, e_dat;
      own    = (m_st == 1);
      ab     = (m_st == 2);
      e_addr = (m_owner == 1) ? 32'(m1_addr) : 32'(m0_addr);
      e_dat  = (m_owner == 1) ? m1_wdat : m0_wdat;
      chk("m_gnt", 32'(gnt), (m_st == 0) ? 32'd0 : ((m_owner == 1) ? 32'd2 : 32'd1));
      chk("m_s_cyc", 32'(s_cyc), 32'(own && req_cyc(m_owner)));
      chk("m_s_stb", 32'(s_stb), 32'(own && req_stb(m_owner)));
      chk("m_s_we", 32'(s_we), 32'(own && ((m_owner == 1) ? m1_we : m0_we)));
      chk("m_s_addr", 32'(s_addr), own ? e_addr : 32'd0);
      chk("m_s_dat", s_wdat, own ? e_dat : 32'd0);
      chk("m_m0_ack", 32'(m0_ack), 32'(m_owner == 0 && ((own && s_ack) || ab)));
      chk("m_m1_ack", 32'(m1_ack), 32'(m_owner == 1 && ((own && s_ack) || ab)));
      chk("m_m0_dat", m0_rdat, (ab && m_owner == 0) ? TDATA : s_rdat);
      chk("m_m1_dat", m1_rdat, (ab && m_owner == 1) ? TDATA : s_rdat);
      chk("m_timeout", 32'(tmo), 32'(ab));
   endtask

   task automatic model_update();
      if (rst) begin
         m_st = 0; m_last = 1; m_wait = 0;
      end else if (m_st == 0) begin
         if (m0_cyc || m1_cyc) begin
            m_owner = (m0_cyc && m1_cyc) ? 1 - m_last : (m0_cyc ? 0 : 1);
            m_last  = m_owner;
            m_st    = 1;
         end
         m_wait = 0;
      end else if (m_st == 1) begin
         if (!req_cyc(m_owner)) begin
            m_st = 0; m_wait = 0;
         end else if (req_stb(m_owner) && !s_ack) begin
            if (m_wait == T - 1) begin
               m_st = 2; m_wait = 0;
            end else begin
               m_wait++;
            end
         end else begin
            m_wait = 0;
         end
      end else begin
         m_st = 1; m_wait = 0;
      end
   endtask

   task automatic settle();
      #3;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      m0_addr = 11'h041; m1_addr = 11'h7C3;
      m0_wdat = 32'hA0A0_0001; m1_wdat = 32'hB1B1_0002;
      s_rdat  = 32'h5555_AAAA;
      tick();
      settle();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_m0_dat", m0_rdat, 32'h5555_AAAA);
      tick();
      rst = 1'b0;

      // M0 read, slave acks on the third strobe cycle
      m0_cyc = 1'b1; m0_stb = 1'b1;
      settle(); chk("rd_stb_req_cycle", 32'(s_stb), 32'd0); tick();
      settle(); chk("rd_stb_next", 32'(s_stb), 32'd1); chk("rd_gnt", 32'(gnt), 32'd1); tick();
      settle(); chk("rd_no_ack", 32'(m0_ack), 32'd0); tick();
      s_ack = 1'b1; s_rdat = 32'h1234_5678;
      settle(); chk("rd_ack", 32'(m0_ack), 32'd1); chk("rd_dat", m0_rdat, 32'h1234_5678); tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      settle(); chk("rd_gnt_hold", 32'(gnt), 32'd1); tick();
      settle(); chk("rd_gnt_idle", 32'(gnt), 32'd0); tick();

      // Repeated ties after reset alternate M0, M1, M0, M1
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle(); chk("rr_idle_gap", 32'(gnt), 32'd0); tick();
         s_ack = 1'b1;
         settle(); chk("rr_gnt", 32'(gnt), (i % 2 == 1) ? 32'd2 : 32'd1); tick();
         s_ack = 1'b0;
         if (i % 2 == 1) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
         else            begin m0_cyc = 1'b0; m0_stb = 1'b0; end
         settle(); tick();
         m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      end
      do_reset();

      // M1 block write of three beats while M0 waits
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
      settle(); tick();
      m0_cyc = 1'b1; m0_stb = 1'b1;
      for (int w = 0; w < 3; w++) begin
         m1_wdat = 32'hC0DE_0000 + 32'(w); s_ack = 1'b1;
         settle();
         chk("blk_gnt", 32'(gnt), 32'd2);
         chk("blk_we", 32'(s_we), 32'd1);
         chk("blk_dat", s_wdat, 32'hC0DE_0000 + 32'(w));
         tick();
      end
      s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
      settle(); tick();
      settle(); chk("blk_gap", 32'(gnt), 32'd0); tick();
      settle(); chk("blk_m0_gnt", 32'(gnt), 32'd1); tick();
      m0_cyc = 1'b0; m0_stb = 1'b0;
      settle(); tick();

      // Watchdog abort: strobe with no ACK
      m0_cyc = 1'b1; m0_stb = 1'b1; s_rdat = 32'h0BAD_F00D;
      settle(); tick();
      for (int k = 0; k < T; k++) begin
         settle(); chk("to_wait_ack", 32'(m0_ack), 32'd0); chk("to_wait_pulse", 32'(tmo), 32'd0);
         tick();
      end
      settle();
      chk("to_ack", 32'(m0_ack), 32'd1);
      chk("to_pulse", 32'(tmo), 32'd1);
      chk("to_dat", m0_rdat, TDATA);
      chk("to_s_stb", 32'(s_stb), 32'd0);
      tick();
      m0_stb = 1'b0;
      settle(); chk("to_pulse_gone", 32'(tmo), 32'd0); tick();

      // ACK arriving on the last watchdog cycle completes normally
      m0_stb = 1'b1;
      for (int k = 0; k < T - 1; k++) begin settle(); tick(); end
      s_ack = 1'b1; s_rdat = 32'h7777_1111;
      settle(); chk("edge_ack", 32'(m0_ack), 32'd1); chk("edge_dat", m0_rdat, 32'h7777_1111);
      chk("edge_no_pulse", 32'(tmo), 32'd0); tick();
      s_ack = 1'b0;
      settle(); chk("edge_no_pulse_after", 32'(tmo), 32'd0); tick();
      m0_cyc = 1'b0; m0_stb = 1'b0;
      settle(); tick();

      // Reset while M1 owns the bus
      m1_cyc = 1'b1; m1_stb = 1'b1;
      settle(); tick();
      settle(); chk("rm_gnt_m1", 32'(gnt), 32'd2); tick();
      rst = 1'b1;
      settle(); tick();
      rst = 1'b0; s_ack = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
      settle();
      chk("rm_gnt", 32'(gnt), 32'd0); chk("rm_stb", 32'(s_stb), 32'd0);
      chk("rm_ack", 32'(m1_ack), 32'd0); chk("rm_pulse", 32'(tmo), 32'd0);
      tick();
      s_ack = 1'b0;
      settle(); chk("rm_tie_m0", 32'(gnt), 32'd1); tick();

      // Random traffic against the model
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
         if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
         m0_stb  = m0_cyc && ($urandom_range(0, 3) != 0);
         m1_stb  = m1_cyc && ($urandom_range(0, 3) != 0);
         m0_we   = 1'($urandom);
         m1_we   = 1'($urandom);
         m0_addr = AW'($urandom);
         m1_addr = AW'($urandom);
         m0_wdat = $urandom;
         m1_wdat = $urandom;
         s_rdat  = $urandom;
         s_ack   = ($urandom_range(0, 11) == 0);
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
